// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control FSM.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC,
        ALUWB,
        BRANCH,
        IMM_EX,
        IMMWB,
        JUMP,
        HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_SLT   = 3'b011;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive cycles spent waiting on memory; expired_o flags the last allowed wait cycle.
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [W-1:0] count;

    // count holds the number of earlier waiting cycles, so the MEM_TIMEOUT-th one expires
    assign expired_o = (MEM_TIMEOUT != 0) && enable_i && (count == W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= '0;
        end else if (clear_i) begin
            count <= '0;
        end else if (enable_i && !expired_o) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle CPU: sequences the shared ALU and unified memory.
module multi_cycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] instr_op_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       iord_o,
    output logic       ir_write_o,
    output logic       pc_en_o,
    output logic [1:0] pc_source_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       instr_done_o,
    output logic       halted_o,
    output logic [1:0] err_o
);

    state_t     state, next_state;
    logic [1:0] err_set;
    logic       timer_clear, timer_enable, timer_expired;

    assign timer_enable = is_wait_state(state) && !mem_ready_i;
    assign timer_clear  = (next_state != state);

    mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (timer_clear),
        .enable_i  (timer_enable),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= FETCH;
            err_o <= '0;
        end else begin
            state <= next_state;
            err_o <= err_o | err_set;
        end
    end

    always_comb begin
        next_state = state;
        err_set    = '0;
        case (state)
            FETCH: begin
                if (mem_ready_i)        next_state = DECODE;
                else if (timer_expired) begin
                    next_state = HALT;
                    err_set    = ERR_TIMEOUT;
                end
            end
            DECODE: begin
                case (instr_op_i)
                    OP_LW, OP_SW:     next_state = MEMADR;
                    OP_RTYPE:         next_state = EXEC;
                    OP_BEQ, OP_BNE:   next_state = BRANCH;
                    OP_ADDI, OP_SLTI: next_state = IMM_EX;
                    OP_J:             next_state = JUMP;
                    default: begin
                        next_state = HALT;
                        err_set    = ERR_ILLEGAL;
                    end
                endcase
            end
            MEMADR: next_state = (instr_op_i == OP_SW) ? MEMWR : MEMRD;
            MEMRD, MEMWR: begin
                if (mem_ready_i)        next_state = (state == MEMRD) ? MEMWB : FETCH;
                else if (timer_expired) begin
                    next_state = HALT;
                    err_set    = ERR_TIMEOUT;
                end
            end
            EXEC:   next_state = ALUWB;
            IMM_EX: next_state = IMMWB;
            MEMWB, ALUWB, IMMWB, BRANCH, JUMP: next_state = FETCH;
            HALT:   next_state = HALT;
            default: next_state = HALT;
        endcase
    end

    always_comb begin
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_en_o      = 1'b0;
        pc_source_o  = PCSRC_ALU;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRCB_REGB;
        alu_op_o     = ALU_ADD;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        instr_done_o = 1'b0;
        halted_o     = 1'b0;
        case (state)
            FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                ir_write_o  = mem_ready_i;
                pc_en_o     = mem_ready_i;
            end
            DECODE: alu_src_b_o = SRCB_IMM_SH2;
            MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
            end
            MEMRD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            MEMWB: begin
                mem_to_reg_o = 1'b1;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            MEMWR: begin
                mem_write_o  = 1'b1;
                iord_o       = 1'b1;
                instr_done_o = mem_ready_i;
            end
            EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_FUNCT;
            end
            ALUWB: begin
                reg_dst_o    = 1'b1;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            BRANCH: begin
                alu_src_a_o  = 1'b1;
                alu_op_o     = ALU_SUB;
                pc_source_o  = PCSRC_ALUOUT;
                instr_done_o = 1'b1;
                pc_en_o      = ((instr_op_i == OP_BEQ) && zero_i) ||
                               ((instr_op_i == OP_BNE) && !zero_i);
            end
            IMM_EX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = (instr_op_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            IMMWB: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            JUMP: begin
                pc_source_o  = PCSRC_JUMP;
                pc_en_o      = 1'b1;
                instr_done_o = 1'b1;
            end
            HALT:    halted_o = 1'b1;
            default: halted_o = 1'b1;
        endcase
        // reset must suppress every write immediately, even before the state register settles
        if (!rst_i) begin
            ir_write_o   = 1'b0;
            pc_en_o      = 1'b0;
            reg_write_o  = 1'b0;
            mem_write_o  = 1'b0;
            instr_done_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks each instruction class, memory waits, timeout and error halts.
module tb_multi_cycle_ctrl;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic       zero;
    logic       ready;

    logic       mem_read, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_source, alu_src_b, err;
    logic       alu_src_a, reg_dst, mem_to_reg, reg_write, instr_done, halted;
    logic [2:0] alu_op;

    int checks = 0;
    int errors = 0;

    multi_cycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .instr_op_i   (op),
        .zero_i       (zero),
        .mem_ready_i  (ready),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .iord_o       (iord),
        .ir_write_o   (ir_write),
        .pc_en_o      (pc_en),
        .pc_source_o  (pc_source),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .alu_op_o     (alu_op),
        .reg_dst_o    (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .reg_write_o  (reg_write),
        .instr_done_o (instr_done),
        .halted_o     (halted),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [19:0] obs = {mem_read, mem_write, iord, ir_write, pc_en, pc_source, alu_src_a,
                       alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, instr_done, halted, err};

    function automatic logic [19:0] sig(input logic mr, input logic mw, input logic io,
                                        input logic irw, input logic pce, input logic [1:0] pcs,
                                        input logic sa, input logic [1:0] sb, input logic [2:0] aop,
                                        input logic rd, input logic m2r, input logic rw,
                                        input logic dn, input logic hl, input logic [1:0] er);
        return {mr, mw, io, irw, pce, pcs, sa, sb, aop, rd, m2r, rw, dn, hl, er};
    endfunction

    // Hand-derived output signatures, fields in port order
    localparam logic [19:0] E_FETCH_WAIT = sig(H,L,L,L,L,2'b00,L,2'b01,3'b000,L,L,L,L,L,2'b00);
    localparam logic [19:0] E_FETCH_RDY  = sig(H,L,L,H,H,2'b00,L,2'b01,3'b000,L,L,L,L,L,2'b00);
    localparam logic [19:0] E_DECODE     = sig(L,L,L,L,L,2'b00,L,2'b11,3'b000,L,L,L,L,L,2'b00);
    localparam logic [19:0] E_MEMADR     = sig(L,L,L,L,L,2'b00,H,2'b10,3'b000,L,L,L,L,L,2'b00);
    localparam logic [19:0] E_MEMRD      = sig(H,L,H,L,L,2'b00,L,2'b00,3'b000,L,L,L,L,L,2'b00);
    localparam logic [19:0] E_MEMWB      = sig(L,L,L,L,L,2'b00,L,2'b00,3'b000,L,H,H,H,L,2'b00);
    localparam logic [19:0] E_MEMWR_WAIT = sig(L,H,H,L,L,2'b00,L,2'b00,3'b000,L,L,L,L,L,2'b00);
    localparam logic [19:0] E_MEMWR_DONE = sig(L,H,H,L,L,2'b00,L,2'b00,3'b000,L,L,L,H,L,2'b00);
    localparam logic [19:0] E_EXEC       = sig(L,L,L,L,L,2'b00,H,2'b00,3'b010,L,L,L,L,L,2'b00);
    localparam logic [19:0] E_ALUWB      = sig(L,L,L,L,L,2'b00,L,2'b00,3'b000,H,L,H,H,L,2'b00);
    localparam logic [19:0] E_BR_TAKEN   = sig(L,L,L,L,H,2'b01,H,2'b00,3'b001,L,L,L,H,L,2'b00);
    localparam logic [19:0] E_BR_NOT     = sig(L,L,L,L,L,2'b01,H,2'b00,3'b001,L,L,L,H,L,2'b00);
    localparam logic [19:0] E_ADDI_EX    = sig(L,L,L,L,L,2'b00,H,2'b10,3'b000,L,L,L,L,L,2'b00);
    localparam logic [19:0] E_SLTI_EX    = sig(L,L,L,L,L,2'b00,H,2'b10,3'b011,L,L,L,L,L,2'b00);
    localparam logic [19:0] E_IMMWB      = sig(L,L,L,L,L,2'b00,L,2'b00,3'b000,L,L,H,H,L,2'b00);
    localparam logic [19:0] E_JUMP       = sig(L,L,L,L,H,2'b10,L,2'b00,3'b000,L,L,L,H,L,2'b00);
    localparam logic [19:0] E_HALT_ILL   = sig(L,L,L,L,L,2'b00,L,2'b00,3'b000,L,L,L,L,H,2'b01);
    localparam logic [19:0] E_HALT_TMO   = sig(L,L,L,L,L,2'b00,L,2'b00,3'b000,L,L,L,L,H,2'b10);

    task automatic apply_stimulus(input logic [5:0] new_op, input logic new_zero, input logic new_ready);
        op    = new_op;
        zero  = new_zero;
        ready = new_ready;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [19:0] observed, input logic [19:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%05h expected=%05h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        apply_stimulus(6'h00, 1'b0, 1'b1);
        check_output("reset_outputs", obs, E_FETCH_WAIT);
        next_cycle();
        rst = 1'b1;

        // lw: five cycles, register write only in the last
        apply_stimulus(6'h23, 1'b0, 1'b1); check_output("lw_c1_fetch", obs, E_FETCH_RDY);
        next_cycle(); apply_stimulus(6'h23, 1'b0, 1'b1); check_output("lw_c2_decode", obs, E_DECODE);
        next_cycle(); apply_stimulus(6'h23, 1'b0, 1'b1); check_output("lw_c3_memadr", obs, E_MEMADR);
        next_cycle(); apply_stimulus(6'h23, 1'b0, 1'b1); check_output("lw_c4_memrd", obs, E_MEMRD);
        next_cycle(); apply_stimulus(6'h23, 1'b0, 1'b1); check_output("lw_c5_memwb", obs, E_MEMWB);
        next_cycle();

        // beq taken, then bne with zero set (not taken), then bne with zero clear
        apply_stimulus(6'h04, 1'b1, 1'b1); check_output("beq_c1_fetch", obs, E_FETCH_RDY);
        next_cycle(); apply_stimulus(6'h04, 1'b1, 1'b1); check_output("beq_c2_decode", obs, E_DECODE);
        next_cycle(); apply_stimulus(6'h04, 1'b1, 1'b1); check_output("beq_c3_taken", obs, E_BR_TAKEN);
        next_cycle();
        apply_stimulus(6'h05, 1'b1, 1'b1); check_output("bne_c1_fetch", obs, E_FETCH_RDY);
        next_cycle(); apply_stimulus(6'h05, 1'b1, 1'b1); check_output("bne_c2_decode", obs, E_DECODE);
        next_cycle(); apply_stimulus(6'h05, 1'b1, 1'b1); check_output("bne_c3_not_taken", obs, E_BR_NOT);
        next_cycle();
        apply_stimulus(6'h05, 1'b0, 1'b1); check_output("bne2_c1_fetch", obs, E_FETCH_RDY);
        next_cycle(); apply_stimulus(6'h05, 1'b0, 1'b1);
        next_cycle(); apply_stimulus(6'h05, 1'b0, 1'b1); check_output("bne2_c3_taken", obs, E_BR_TAKEN);
        next_cycle();

        // R-type
        apply_stimulus(6'h00, 1'b0, 1'b1); check_output("r_c1_fetch", obs, E_FETCH_RDY);
        next_cycle(); apply_stimulus(6'h00, 1'b0, 1'b1); check_output("r_c2_decode", obs, E_DECODE);
        next_cycle(); apply_stimulus(6'h00, 1'b0, 1'b1); check_output("r_c3_exec", obs, E_EXEC);
        next_cycle(); apply_stimulus(6'h00, 1'b0, 1'b1); check_output("r_c4_aluwb", obs, E_ALUWB);
        next_cycle();

        // slti
        apply_stimulus(6'h0A, 1'b0, 1'b1);
        next_cycle(); apply_stimulus(6'h0A, 1'b0, 1'b1);
        next_cycle(); apply_stimulus(6'h0A, 1'b0, 1'b1); check_output("slti_c3_immex", obs, E_SLTI_EX);
        next_cycle(); apply_stimulus(6'h0A, 1'b0, 1'b1); check_output("slti_c4_immwb", obs, E_IMMWB);
        next_cycle();

        // j
        apply_stimulus(6'h02, 1'b0, 1'b1);
        next_cycle(); apply_stimulus(6'h02, 1'b0, 1'b1);
        next_cycle(); apply_stimulus(6'h02, 1'b0, 1'b1); check_output("j_c3_jump", obs, E_JUMP);
        next_cycle();

        // sw with ready low 3 cycles; ready arrives on the limit cycle and must win
        apply_stimulus(6'h2B, 1'b0, 1'b1); check_output("sw_c1_fetch", obs, E_FETCH_RDY);
        next_cycle(); apply_stimulus(6'h2B, 1'b0, 1'b1);
        next_cycle(); apply_stimulus(6'h2B, 1'b0, 1'b1); check_output("sw_c3_memadr", obs, E_MEMADR);
        next_cycle(); apply_stimulus(6'h2B, 1'b0, 1'b0); check_output("sw_wait1", obs, E_MEMWR_WAIT);
        next_cycle(); apply_stimulus(6'h2B, 1'b0, 1'b0); check_output("sw_wait2", obs, E_MEMWR_WAIT);
        next_cycle(); apply_stimulus(6'h2B, 1'b0, 1'b0); check_output("sw_wait3", obs, E_MEMWR_WAIT);
        next_cycle(); apply_stimulus(6'h2B, 1'b0, 1'b1); check_output("sw_ready_done", obs, E_MEMWR_DONE);
        next_cycle(); apply_stimulus(6'h08, 1'b0, 1'b1); check_output("sw_back_to_fetch", obs, E_FETCH_RDY);

        // addi, reset asserted mid-cycle during IMMWB
        next_cycle(); apply_stimulus(6'h08, 1'b0, 1'b1); check_output("addi_c2_decode", obs, E_DECODE);
        next_cycle(); apply_stimulus(6'h08, 1'b0, 1'b1); check_output("addi_c3_immex", obs, E_ADDI_EX);
        next_cycle(); apply_stimulus(6'h08, 1'b0, 1'b1); check_output("addi_c4_immwb", obs, E_IMMWB);
        #1 rst = 1'b0;
        #1 check_output("addi_async_reset", obs, E_FETCH_WAIT);
        next_cycle();
        rst = 1'b1;
        apply_stimulus(6'h3F, 1'b0, 1'b1); check_output("after_reset_fetch", obs, E_FETCH_RDY);

        // illegal opcode
        next_cycle(); apply_stimulus(6'h3F, 1'b0, 1'b1); check_output("ill_decode", obs, E_DECODE);
        next_cycle(); apply_stimulus(6'h3F, 1'b0, 1'b1); check_output("ill_halt", obs, E_HALT_ILL);
        next_cycle(); apply_stimulus(6'h3F, 1'b1, 1'b1); check_output("ill_halt_stays", obs, E_HALT_ILL);
        rst = 1'b0;
        apply_stimulus(6'h00, 1'b0, 1'b0); check_output("err_cleared_by_reset", obs, E_FETCH_WAIT);
        next_cycle();
        rst = 1'b1;

        // fetch timeout with MEM_TIMEOUT = 4
        apply_stimulus(6'h00, 1'b0, 1'b0); check_output("tmo_wait1", obs, E_FETCH_WAIT);
        next_cycle(); apply_stimulus(6'h00, 1'b0, 1'b0); check_output("tmo_wait2", obs, E_FETCH_WAIT);
        next_cycle(); apply_stimulus(6'h00, 1'b0, 1'b0); check_output("tmo_wait3", obs, E_FETCH_WAIT);
        next_cycle(); apply_stimulus(6'h00, 1'b0, 1'b0); check_output("tmo_wait4", obs, E_FETCH_WAIT);
        next_cycle(); apply_stimulus(6'h00, 1'b0, 1'b0); check_output("tmo_halt", obs, E_HALT_TMO);
        next_cycle(); apply_stimulus(6'h23, 1'b0, 1'b1); check_output("tmo_halt_ignores_ready", obs, E_HALT_TMO);
        next_cycle(); apply_stimulus(6'h23, 1'b0, 1'b1); check_output("tmo_halt_stays", obs, E_HALT_TMO);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
